// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: takes a desired word over valid/ready and drives the
// J/K excitation of a WIDTH-bit JK flop bank. It reads Q back, retries up to
// MAX_RETRY times on mismatch, and then pulses done or err.
// Optional build macro: JK_TOGGLE_EN selects toggle (J=K=1) encoding for
// changing bits instead of set/reset encoding.
module jk_excitation_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] diff;

    // State, target, retry count and result pulses; clr drops any request in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: IDLE accepts, DRIVE lasts one cycle, CHECK compares Q with the target
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    retry_d = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: state_d = S_CHECK;
            S_CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (retry_q < RMAX) begin
                    // The guard keeps the counter from ever wrapping
                    retry_d = retry_q + 1'b1;
                    state_d = S_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Excitation: only bits that differ from the target are driven, and only during DRIVE
    always_comb begin
        diff = q_fb ^ tgt_q;
        j    = '0;
        k    = '0;
        if (state_q == S_DRIVE) begin
`ifdef JK_TOGGLE_EN
            j = diff;
            k = diff;
`else
            j = diff & tgt_q;
            k = diff & ~tgt_q;
`endif
        end
    end

    assign tgt_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign done      = done_q;
    assign err       = err_q;

endmodule
